// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Serialises one DATA_BITS word per frame: start bit (0), LSB-first data,
// optional parity bit, then STOP_BITS stop bits (1). Every bit is held for
// BAUD_DIV clock cycles.
//
// Ports:
//   CLKIN  - single clock, all logic on the rising edge
//   RESET  - synchronous active-high reset, has priority over valid
//   data   - word to send, sampled only on the accept edge
//   valid  - client offers a word on data
//   ready  - transmitter can accept (high only in idle)
//   out    - serial line, idles high (mark)
//   busy   - frame in progress (any state except idle)
module uart_tx_frame #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned BAUD_DIV  = 414,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 out,
    output logic                 busy
);

    if (BAUD_DIV < 2) begin : gen_bad_baud
        $fatal(1, "uart_tx_frame: BAUD_DIV must be >= 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
        $fatal(1, "uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY > 2) begin : gen_bad_parity
        $fatal(1, "uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data
        $fatal(1, "uart_tx_frame: DATA_BITS must be in 5..9");
    end

    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned CW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [CW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   bit_end;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        ready   = 1'b0;
        busy    = 1'b1;
        out     = 1'b1;
        bit_end = (baud_q == BAUD_LAST);

        // One shared baud counter paces every bit of every state.
        if (state_q != StIdle) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                ready  = 1'b1;
                busy   = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                if (valid) begin
                    shift_d = data;
                    par_d   = (^data) ^ ODD_PAR;
                    state_d = StStart;
                end
            end
            StStart: begin
                out = 1'b0;
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                out = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StParity: begin
                out = par_q;
                if (bit_end) begin
                    state_d = StStop;
                    bit_d   = '0;
                end
            end
            StStop: begin
                // bit_q counts stop periods here.
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = StIdle;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
        end
    end

endmodule
